// File: rtl/fifo_banked_if.sv
// Handshake, data and status bundle for fifo_banked.
// The master side drives requests; the slave side (the FIFO) returns data and status.
interface fifo_banked_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned CW         = 13
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;
  logic [NUM_BANKS-1:0]  bank_empty;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow, bank_empty
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow, bank_empty
  );
endinterface

// File: rtl/fifo_banked.sv
// Single-clock FIFO over NUM_BANKS power-of-two banks addressed as one circular buffer,
// with registered read data, occupancy flags, error pulses and per-bank empty status.
module fifo_banked #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned BANK_DEPTH    = 2048,
  parameter int unsigned NUM_BANKS     = 2,
  parameter int unsigned AFULL_THRESH  = NUM_BANKS * BANK_DEPTH - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input logic          clk,
  input logic          rst,
  fifo_banked_if.slave bus
);
  localparam int unsigned DEPTH = NUM_BANKS * BANK_DEPTH;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned BW    = $clog2(BANK_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned BCW   = BW + 1;
  localparam int unsigned KW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][BANK_DEPTH];

  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_nxt;
  logic [BCW-1:0]        bank_cnt_q [NUM_BANKS];
  logic [BCW-1:0]        bank_cnt_nxt [NUM_BANKS];
  logic [NUM_BANKS-1:0]  bank_empty_q, bank_empty_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  rd_valid_q, full_q, empty_q, afull_q, aempty_q;
  logic                  overflow_q, underflow_q;
  logic                  wr_acc, rd_acc;
  logic [KW-1:0]         wr_bank, rd_bank;
  logic [BW-1:0]         wr_addr, rd_addr;

  // Shift rather than slice so a single bank (AW == BW) yields bank 0.
  assign wr_bank = KW'(wr_ptr_q >> BW);
  assign rd_bank = KW'(rd_ptr_q >> BW);
  assign wr_addr = wr_ptr_q[BW-1:0];
  assign rd_addr = rd_ptr_q[BW-1:0];

  assign wr_acc = bus.wr_en && !full_q  && !bus.flush;
  assign rd_acc = bus.rd_en && !empty_q && !bus.flush;

  always_comb begin
    count_nxt = bus.flush ? '0 : count_q + CW'(wr_acc) - CW'(rd_acc);
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      bank_cnt_nxt[i] = bank_cnt_q[i];
      if (wr_acc && wr_bank == KW'(i)) bank_cnt_nxt[i] = bank_cnt_nxt[i] + BCW'(1);
      if (rd_acc && rd_bank == KW'(i)) bank_cnt_nxt[i] = bank_cnt_nxt[i] - BCW'(1);
      if (bus.flush) bank_cnt_nxt[i] = '0;
      bank_empty_nxt[i] = (bank_cnt_nxt[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_bank][wr_addr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      bank_cnt_q   <= '{default: '0};
      bank_empty_q <= '1;
      data_q       <= '0;
      rd_valid_q   <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      afull_q      <= 1'b0;
      aempty_q     <= 1'b1;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= bus.flush ? '0 : wr_ptr_q + AW'(wr_acc);
      rd_ptr_q     <= bus.flush ? '0 : rd_ptr_q + AW'(rd_acc);
      count_q      <= count_nxt;
      bank_cnt_q   <= bank_cnt_nxt;
      bank_empty_q <= bank_empty_nxt;
      if (rd_acc) data_q <= mem[rd_bank][rd_addr];
      rd_valid_q   <= rd_acc;
      full_q       <= (count_nxt == CW'(DEPTH));
      empty_q      <= (count_nxt == '0);
      afull_q      <= (count_nxt >= CW'(AFULL_THRESH));
      aempty_q     <= (count_nxt <= CW'(AEMPTY_THRESH));
      overflow_q   <= bus.wr_en && full_q  && !bus.flush;
      underflow_q  <= bus.rd_en && empty_q && !bus.flush;
    end
  end

  assign bus.data_out     = data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.bank_empty   = bank_empty_q;
endmodule

// File: tb/tb_fifo_banked.sv
// Bench for fifo_banked (4 banks x 4 entries): table of vectors with a queue reference,
// plus hand-written sequences for full/empty collisions, flush and asynchronous reset.
module tb_fifo_banked;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_banked_if #(.DATA_WIDTH(16), .NUM_BANKS(4), .CW(5)) bus ();

  fifo_banked #(
    .DATA_WIDTH(16), .BANK_DEPTH(4), .NUM_BANKS(4),
    .AFULL_THRESH(14), .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          fl, wr, rd;
    logic [15:0] din;
    logic [4:0]  e_cnt;
    logic [6:0]  e_flags;  // {full, empty, afull, aempty, overflow, underflow, rd_valid}
    logic [3:0]  e_bank;
    logic [15:0] e_dout;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] mq[$];
  int          mbank[4];
  int          mwp, mrp;
  logic [15:0] mdout;
  int          checks = 0;
  int          failures = 0;

  function automatic void add(bit fl, bit wr, bit rd, logic [15:0] din);
    vec_t v;
    int   n     = mq.size();
    bit   mfull = (n == 16);
    bit   memp  = (n == 0);
    bit   aw    = wr && !mfull && !fl;
    bit   ar    = rd && !memp && !fl;
    v.fl = fl; v.wr = wr; v.rd = rd; v.din = din;
    if (fl) begin
      mq.delete(); mwp = 0; mrp = 0;
      for (int b = 0; b < 4; b++) mbank[b] = 0;
    end else begin
      if (ar) begin mdout = mq.pop_front(); mbank[mrp / 4]--; mrp = (mrp + 1) % 16; end
      if (aw) begin mq.push_back(din); mbank[mwp / 4]++; mwp = (mwp + 1) % 16; end
    end
    n = mq.size();
    v.e_cnt   = 5'(n);
    v.e_flags = {n == 16, n == 0, n >= 14, n <= 2, wr && mfull && !fl, rd && memp && !fl, ar};
    for (int b = 0; b < 4; b++) v.e_bank[b] = (mbank[b] == 0);
    v.e_dout = mdout;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit fl, input bit wr, input bit rd, input logic [15:0] din);
    bus.flush = fl; bus.wr_en = wr; bus.rd_en = rd; bus.data_in = din;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] flags();
    return {bus.full, bus.empty, bus.almost_full, bus.almost_empty,
            bus.overflow, bus.underflow, bus.rd_valid};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mwp = 0; mrp = 0; mdout = '0;
    for (int b = 0; b < 4; b++) mbank[b] = 0;

    add(0, 0, 0, 16'h0);
    for (int k = 1; k <= 16; k++) add(0, 1, 0, 16'(k));
    add(0, 1, 0, 16'h0011);
    add(0, 0, 0, 16'h0);
    for (int k = 0; k < 17; k++) add(0, 0, 1, 16'h0);
    add(0, 0, 0, 16'h0);
    for (int k = 0; k < 10; k++) add(0, 1, 0, 16'h0100 + 16'(k));
    for (int k = 0; k < 10; k++) add(0, 0, 1, 16'h0);
    for (int k = 0; k < 12; k++) add(0, 1, 0, 16'h0200 + 16'(k));
    for (int k = 0; k < 12; k++) add(0, 0, 1, 16'h0);
    for (int k = 0; k < 7; k++)  add(0, 1, 0, 16'h0300 + 16'(k));
    for (int k = 0; k < 6; k++)  add(0, 1, 1, 16'h0400 + 16'(k));
    for (int k = 0; k < 7; k++)  add(0, 0, 1, 16'h0);

    bus.flush = 0; bus.wr_en = 0; bus.rd_en = 0; bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 32'(bus.count), 0);
    chk("reset_flags", 32'(flags()), 32'b0101000);
    chk("reset_bank_empty", 32'(bus.bank_empty), 32'hF);
    chk("reset_data_out", 32'(bus.data_out), 0);
    #2 rst = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].fl, tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_flags", i), 32'(flags()), 32'(tbl[i].e_flags));
      chk($sformatf("v%0d_bank_empty", i), 32'(bus.bank_empty), 32'(tbl[i].e_bank));
      chk($sformatf("v%0d_data_out", i), 32'(bus.data_out), 32'(tbl[i].e_dout));
    end

    // Full: simultaneous read+write takes the read, rejects the write.
    cyc(1, 0, 0, 16'h0);
    for (int k = 0; k < 16; k++) cyc(0, 1, 0, 16'hA000 + 16'(k));
    chk("fill_count", 32'(bus.count), 16);
    chk("fill_full", 32'(bus.full), 1);
    cyc(0, 1, 1, 16'hBEEF);
    chk("rw_full_count", 32'(bus.count), 15);
    chk("rw_full_overflow", 32'(bus.overflow), 1);
    chk("rw_full_rd_valid", 32'(bus.rd_valid), 1);
    chk("rw_full_data", 32'(bus.data_out), 32'hA000);
    for (int k = 1; k < 16; k++) cyc(0, 0, 1, 16'h0);
    chk("drain_data", 32'(bus.data_out), 32'hA00F);
    chk("drain_empty", 32'(bus.empty), 1);

    // Empty: simultaneous read+write takes the write, rejects the read.
    cyc(0, 1, 1, 16'hC0DE);
    chk("rw_empty_count", 32'(bus.count), 1);
    chk("rw_empty_underflow", 32'(bus.underflow), 1);
    chk("rw_empty_rd_valid", 32'(bus.rd_valid), 0);
    chk("rw_empty_data_hold", 32'(bus.data_out), 32'hA00F);
    cyc(0, 0, 1, 16'h0);
    chk("rw_empty_readback", 32'(bus.data_out), 32'hC0DE);
    chk("rw_empty_readback_valid", 32'(bus.rd_valid), 1);

    // Flush at count 9 with concurrent requests.
    for (int k = 0; k < 9; k++) cyc(0, 1, 0, 16'h0500 + 16'(k));
    chk("pre_flush_count", 32'(bus.count), 9);
    cyc(1, 1, 1, 16'hDEAD);
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_flags", 32'(flags()), 32'b0101000);
    chk("flush_bank_empty", 32'(bus.bank_empty), 32'hF);
    chk("flush_data_hold", 32'(bus.data_out), 32'hC0DE);
    cyc(0, 1, 0, 16'h0055);
    cyc(0, 0, 1, 16'h0);
    chk("post_flush_data", 32'(bus.data_out), 32'h0055);
    chk("post_flush_count", 32'(bus.count), 0);

    // Asynchronous reset mid-stream, sampled before any clock edge.
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, 16'h0600 + 16'(k));
    cyc(0, 0, 1, 16'h0);
    chk("pre_rst_data", 32'(bus.data_out), 32'h0600);
    bus.rd_en = 0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(bus.count), 0);
    chk("async_rst_flags", 32'(flags()), 32'b0101000);
    chk("async_rst_bank_empty", 32'(bus.bank_empty), 32'hF);
    chk("async_rst_data_out", 32'(bus.data_out), 0);
    #3 rst = 1'b1;
    cyc(0, 0, 0, 16'h0);
    chk("post_rst_empty", 32'(bus.empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_banked.md
# fifo_banked

Parametrised single-clock FIFO built from NUM_BANKS power-of-two storage banks addressed as one circular buffer. Strict first-in-first-out ordering is kept across bank boundaries. It presents one read port with registered output and a valid strobe, plus occupancy count, almost-full/almost-empty thresholds, overflow/underflow pulses, per-bank empty status and synchronous flush. It is the general replacement for the fixed two-bank 4096-entry buffer in the datapath.

## Interface
- DATA_WIDTH, 16, word width
- BANK_DEPTH, 2048, entries per bank; power of two, ≥2
- NUM_BANKS, 2, bank count; power of two, ≥1
- AFULL_THRESH, NUM_BANKS*BANK_DEPTH-4, almost_full asserts at count ≥ this
- AEMPTY_THRESH, 4, almost_empty asserts at count ≤ this
- Derived: DEPTH=NUM_BANKS*BANK_DEPTH, AW=$clog2(DEPTH), BW=$clog2(BANK_DEPTH), CW=AW+1
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear; dominates wr_en/rd_en
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- data_out  out  DATA_WIDTH  read data, registered
- rd_valid  out  1  data_out valid, one-cycle pulse per accepted read
- full  out  1  count==DEPTH
- empty  out  1  count==0
- almost_full  out  1  count ≥ AFULL_THRESH
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- count  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write requested while full
- underflow  out  1  one-cycle pulse: read requested while empty
- bank_empty  out  NUM_BANKS  bit i high when bank i holds no entries

## Operation
- wr_ptr, rd_ptr: AW-bit, wrap modulo DEPTH. Bank = ptr[AW-1:BW]; bank address = ptr[BW-1:0]. Bank index wraps from NUM_BANKS-1 to 0.
- Write accepted when wr_en && !full && !flush: mem[wr_ptr]<=data_in, wr_ptr+1, bank counter of target bank +1.
- Read accepted when rd_en && !empty && !flush: data_out<=mem[rd_ptr], rd_valid<=1, rd_ptr+1, bank counter of source bank -1.
- Accept decisions use the registered full/empty of the current cycle only. Full with simultaneous rd+wr: read accepted, write rejected, overflow pulses. Empty with simultaneous rd+wr: write accepted, read rejected, underflow pulses.
- count next = count + accepted_wr − accepted_rd; all flags registered from next count.
- Per-bank counters are BW+1 bits; bank_empty[i] = (bank_cnt[i]==0), registered.
- flush: pointers, count, bank counters to 0; empty=1, almost_empty=1, full=0, almost_full=0, bank_empty all 1; rd_valid=0; data_out holds; overflow/underflow=0; storage contents untouched.
- NUM_BANKS=1 degenerates to a plain circular FIFO of BANK_DEPTH.

## Timing
- Reset (rst low, async): data_out=0, rd_valid=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, bank_empty=all 1, pointers 0. Release is synchronous to the next clk edge.
- Read latency: rd_en accepted at edge N → data_out/rd_valid valid after edge N, for cycle N+1 only (rd_valid drops unless a new read is accepted). data_out holds the last value otherwise.
- Write-to-read: write at edge N → empty low after edge N → earliest read accepted at edge N+1, data after it.
- Flags, count and bank_empty update on the same edge as the accepting transfer; no combinational input-to-output paths.
- Sustained 1 read + 1 write per cycle at any non-boundary occupancy; count constant.
- overflow/underflow assert on the edge that evaluates the rejected request and clear the next cycle unless repeated.

## Test plan (BANK_DEPTH=4, NUM_BANKS=4, DEPTH=16, AFULL_THRESH=14, AEMPTY_THRESH=2)
- Reset then idle → empty=1, almost_empty=1, count=0, bank_empty=4'b1111, data_out=0, rd_valid=0.
- Write 0x0001..0x0010 (16 writes), then one more → full=1 after 16th; almost_full=1 after 14th; bank_empty=4'b0000; 17th write pulses overflow=1, count stays 16.
- Read all 16 → data_out 0x0001..0x0010 in order, each with rd_valid one cycle later; bank_empty bits set 0,1,2,3 in turn; a 17th read pulses underflow.
- Wrap: write 10, read 10, write 12, read 12 → output order intact across bank 3→0 wrap; count returns to 0.
- Simultaneous rd+wr at count=16 → read accepted, write rejected, overflow=1, count=15. At count=0 → write accepted, underflow=1, count=1. At count=7 → count stays 7.
- Flush at count=9 concurrent with wr_en/rd_en → next cycle count=0, empty=1, no rd_valid; assert rst mid-stream → all outputs at reset values immediately, without a clock edge.
